// File: rtl/seq_div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  // Counter must hold the value N, so it needs $clog2(N+1) bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/subtract.sv
// N-bit subtractor with borrow-in; o_carry is the borrow out of the MSB.
module subtract #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_carry,
  output logic [N-1:0] o_diff,
  output logic         o_carry
);

  logic [N:0] full;

  assign full    = {1'b0, i_a} - {1'b0, i_b} - {{N{1'b0}}, i_carry};
  assign o_diff  = full[N-1:0];
  assign o_carry = full[N];

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per CALC cycle, fixed latency of N
// cycles (1 cycle for a zero divisor), results held until the next completion.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_zero
);

  localparam int unsigned CntW = cnt_width(N);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    div_q, div_d;
  logic            zero_pend_q, zero_pend_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;
  logic [N-1:0]    q_out_q, q_out_d;
  logic [N-1:0]    r_out_q, r_out_d;

  logic [N:0] shifted;
  logic [N:0] divisor_ext;
  logic [N:0] trial;
  logic       borrow;

  assign shifted     = {rem_q, quo_q[N-1]};
  assign divisor_ext = {1'b0, div_q};

  subtract #(
    .N(N + 1)
  ) u_sub (
    .i_a    (shifted),
    .i_b    (divisor_ext),
    .i_carry(1'b0),
    .o_diff (trial),
    .o_carry(borrow)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    zero_pend_d = zero_pend_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dz_d        = dz_q;
    q_out_d     = q_out_q;
    r_out_d     = r_out_q;

    case (state_q)
      StIdle: begin
        if (zero_pend_q) begin
          // Zero divisor waits one cycle in IDLE so o_done lands one edge after start.
          zero_pend_d = 1'b0;
          state_d     = StDone;
          done_d      = 1'b1;
          dz_d        = 1'b1;
          q_out_d     = '1;
          r_out_d     = quo_q;
        end else if (i_start) begin
          div_d = i_divisor;
          quo_d = i_dividend;
          rem_d = '0;
          cnt_d = CntW'(N);
          if (i_divisor == '0) begin
            zero_pend_d = 1'b1;
          end else begin
            state_d = StCalc;
            busy_d  = 1'b1;
          end
        end
      end
      StCalc: begin
        rem_d = borrow ? shifted[N-1:0] : trial[N-1:0];
        quo_d = {quo_q[N-2:0], ~borrow};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = 1'b0;
          q_out_d = quo_d;
          r_out_d = rem_d;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      zero_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dz_q        <= 1'b0;
      q_out_q     <= '0;
      r_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      zero_pend_q <= zero_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dz_q        <= dz_d;
      q_out_q     <= q_out_d;
      r_out_q     <= r_out_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_quotient  = q_out_q;
  assign o_remainder = r_out_q;
  assign o_div_zero  = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks for seq_divider at N=8.
module tb_seq_divider;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_dividend = '0;
  logic [7:0] i_divisor = '0;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_quotient;
  logic [7:0] o_remainder;
  logic       o_div_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(
    .N(8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_quotient (o_quotient),
    .o_remainder(o_remainder),
    .o_div_zero (o_div_zero)
  );

  always #5 i_clk = ~i_clk;

  // Start a division and watch the falling edges after the start edge; index m
  // is the interval between edges k+m and k+m+1. glitch_at re-asserts start there.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int glitch_at,
                         output logic [7:0] q, output logic [7:0] r, output logic dz,
                         output int lat, output int busy_cycles);
    @(negedge i_clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge i_clk);
    lat = -1;
    busy_cycles = 0;
    q = 'x;
    r = 'x;
    dz = 1'bx;
    for (int m = 0; m < 30; m++) begin
      @(negedge i_clk);
      if (m == 0) i_start = 1'b0;
      if (m == glitch_at) begin
        i_start    = 1'b1;
        i_dividend = 8'd9;
        i_divisor  = 8'd3;
      end
      if (glitch_at >= 0 && m == glitch_at + 1) i_start = 1'b0;
      if (o_busy) busy_cycles++;
      if (o_done) begin
        lat = m;
        q   = o_quotient;
        r   = o_remainder;
        dz  = o_div_zero;
        break;
      end
    end
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({o_busy, o_done, o_quotient, o_remainder, o_div_zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               o_busy, o_done, o_quotient, o_remainder, o_div_zero);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q, r;
    logic dz;
    int lat, busy;
    run_div(8'd100, 8'd7, -1, q, r, dz, lat, busy);
    checks++;
    if (q !== 8'd14 || r !== 8'd2) begin
      errors++;
      $display("FAIL basic_100_7: got q=%0d r=%0d, want q=14 r=2", q, r);
    end
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want 8", lat);
    end
    checks++;
    if (busy !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want 8", busy);
    end
    checks++;
    if (dz !== 1'b0) begin
      errors++;
      $display("FAIL basic_div_zero: got %b, want 0", dz);
    end
    @(negedge i_clk);
    checks++;
    if (o_done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: o_done got %b, want 0", o_done);
    end
    repeat (4) @(negedge i_clk);
    checks++;
    if (o_quotient !== 8'd14 || o_remainder !== 8'd2) begin
      errors++;
      $display("FAIL result_hold: got q=%0d r=%0d, want 14 2", o_quotient, o_remainder);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va[4] = '{8'd255, 8'd5, 8'd255, 8'd200};
    logic [7:0] vb[4] = '{8'd1, 8'd10, 8'd255, 8'd13};
    logic [7:0] eq[4] = '{8'd255, 8'd0, 8'd1, 8'd15};
    logic [7:0] er[4] = '{8'd0, 8'd5, 8'd0, 8'd5};
    logic [7:0] q, r;
    logic dz;
    int lat, busy;
    for (int i = 0; i < 4; i++) begin
      run_div(va[i], vb[i], -1, q, r, dz, lat, busy);
      checks++;
      if (q !== eq[i] || r !== er[i] || lat !== 8) begin
        errors++;
        $display("FAIL vector_%0d_%0d: got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=8",
                 va[i], vb[i], q, r, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r;
    logic dz;
    int lat, busy;
    run_div(8'd42, 8'd0, -1, q, r, dz, lat, busy);
    checks++;
    if (q !== 8'hFF || r !== 8'd42 || dz !== 1'b1) begin
      errors++;
      $display("FAIL div_zero_result: got q=%0h r=%0d dz=%b, want q=ff r=42 dz=1", q, r, dz);
    end
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL div_zero_latency: got %0d, want 1", lat);
    end
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL div_zero_busy: got %0d busy cycles, want 0", busy);
    end
    run_div(8'd9, 8'd4, -1, q, r, dz, lat, busy);
    checks++;
    if (dz !== 1'b0 || q !== 8'd2 || r !== 8'd1) begin
      errors++;
      $display("FAIL div_zero_clears: got q=%0d r=%0d dz=%b, want 2 1 0", q, r, dz);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, r;
    logic dz;
    int lat, busy, extra;
    run_div(8'd100, 8'd7, 2, q, r, dz, lat, busy);
    checks++;
    if (q !== 8'd14 || r !== 8'd2 || lat !== 8) begin
      errors++;
      $display("FAIL start_in_calc: got q=%0d r=%0d lat=%0d, want 14 2 8", q, r, lat);
    end
    extra = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_done || o_busy) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL no_second_op: got %0d busy/done cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [7:0] q, r;
    logic dz;
    int lat, busy, seen;
    @(negedge i_clk);
    i_dividend = 8'd100;
    i_divisor  = 8'd7;
    i_start    = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_busy, o_done, o_quotient, o_remainder, o_div_zero} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_calc: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               o_busy, o_done, o_quotient, o_remainder, o_div_zero);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge i_clk);
      if (o_done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_no_done: got %0d done pulses, want 0", seen);
    end
    run_div(8'd200, 8'd13, -1, q, r, dz, lat, busy);
    checks++;
    if (q !== 8'd15 || r !== 8'd5 || lat !== 8) begin
      errors++;
      $display("FAIL after_reset_200_13: got q=%0d r=%0d lat=%0d, want 15 5 8", q, r, lat);
    end
  endtask

  task automatic test_random();
    logic [7:0] bnd[7] = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};
    logic [7:0] a, b, q, r, wq, wr;
    logic dz;
    int lat, busy, wlat;
    for (int i = 0; i < 49 + 2000; i++) begin
      if (i < 49) begin
        a = bnd[i / 7];
        b = bnd[i % 7];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      run_div(a, b, -1, q, r, dz, lat, busy);
      if (b == 8'd0) begin
        wq = 8'hFF;
        wr = a;
        wlat = 1;
      end else begin
        wq = a / b;
        wr = a % b;
        wlat = 8;
      end
      checks++;
      if (q !== wq || r !== wr || dz !== (b == 8'd0) || lat !== wlat) begin
        errors++;
        $display("FAIL random_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d, want q=%0d r=%0d lat=%0d",
                 a, b, q, r, dz, lat, wq, wr, wlat);
      end
      if (b != 8'd0) begin
        checks++;
        if (16'(q) * 16'(b) + 16'(r) !== 16'(a) || r >= b) begin
          errors++;
          $display("FAIL identity_%0d_%0d: got q=%0d r=%0d, want a=q*b+r and r<b", a, b, q, r);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
